uart_core_param: RTL and testbench
==================================

Name: uart_core_param

Overview:
- Parametrised full-duplex UART core; next generation of the team's fixed 8N1 `uarttop`.
- Adds:
  - configurable data width, parity mode and stop-bit count;
  - an oversampled, glitch-rejecting receiver with parity and framing error flags;
  - a TX busy indication.
- Sits between the system bus/register block and the device pins; one instance per serial channel.

Parameters:
- CLK_FREQ, 1000000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- DATA_BITS, 8: payload bits per frame; legal range 5–9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: TX stop bits; legal values 1 or 2. RX always checks only the first stop bit.
- OVERSAMPLE, 16: RX sample ticks per bit; must be even and ≥ 8.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset (rst=0 at a rising clk edge resets the block).
- rx  in  1  serial input; asynchronous to clk.
- dintx  in  DATA_BITS  TX payload; sampled when a frame is accepted.
- newd  in  1  TX request.
- tx  out  1  serial output.
- doutrx  out  DATA_BITS  last received payload.
- donetx  out  1  one-cycle pulse at the end of a TX frame.
- donerx  out  1  one-cycle pulse when a new RX frame is available.
- busytx  out  1  high while a TX frame is in progress.
- perr  out  1  parity error of the last received frame.
- ferr  out  1  framing error of the last received frame.

Behaviour:
- Dividers:
  - BIT_DIV = CLK_FREQ/BAUD clocks per TX bit, integer truncation.
  - SMP_DIV = CLK_FREQ/(BAUD*OVERSAMPLE) clocks per RX sample tick.
  - Both dividers are free-running counters that restart at each frame start. No separate slow clock is generated.
- Reset values:
  - tx=1, busytx=0, donetx=0, donerx=0, doutrx=0, perr=0, ferr=0.
  - rx synchroniser flops = 1; both FSMs go to IDLE.
  - Reset wins over any operation in progress; the partial frame is discarded with no done pulse.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If newd=1, latch dintx; busytx=1 and tx=0 from the next cycle.
  - Each state holds tx for exactly BIT_DIV clocks.
  - DATA: LSB first.
  - PARITY: entered only when PARITY≠0. Even mode sends XOR of the data bits; odd mode sends its inverse.
  - STOP: tx=1 for STOP_BITS×BIT_DIV clocks.
  - In the final cycle of STOP: donetx=1 for one cycle. On the next cycle busytx=0 and the FSM is in IDLE.
  - newd while busytx=1 is ignored and not queued.
  - If newd is held high, the next frame starts in the IDLE cycle after donetx. Gap = 1 clock of idle-high.
- RX path: 2-flop synchroniser on rx; all decisions use the synchronised value.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on synchronised rx=0, go to START.
  - START: after OVERSAMPLE/2 ticks, re-sample.
    - If 1: treat as a glitch and return to IDLE with no pulse and no flag change.
    - Else: advance.
  - Subsequent bits are sampled every OVERSAMPLE ticks (bit centres). Data are shifted LSB first.
  - PARITY: sampled when PARITY≠0. perr = mismatch against the mode; perr is always 0 when PARITY=0.
  - STOP: sample the first stop bit; ferr = (sample==0).
  - On the cycle after the stop sample, update doutrx, perr and ferr and pulse donerx for 1 cycle. Then go to IDLE.
  - doutrx, perr and ferr hold until the next donerx.
  - After a framing error, IDLE waits for rx=1 before accepting a new start bit, so a break does not retrigger.
- TX and RX are fully independent. Simultaneous events on both sides need no arbitration.

Optional Feature:
- Macro UART_LOOPBACK_EN.
- When defined:
  - Extra input port loopback (1 bit).
  - loopback=1: the RX synchroniser input is the internal tx; the external rx is ignored; the tx pin is forced to 1.
  - loopback=0: normal operation.
- When undefined: no loopback port; RX always uses the external rx.

Test Plan:
- Defaults (8N1, BIT_DIV=104): newd=1 with dintx=8'hA5 for one cycle ->
  - busytx=1;
  - tx = 0 for 104 clocks, then bits 1,0,1,0,0,1,0,1 at 104 clocks each, then 1;
  - donetx pulse 1040 clocks after the start bit began.
- DATA_BITS=7, PARITY=2, STOP_BITS=2: send 7'h41 ->
  - data bits 1,0,0,0,0,0,1, then parity bit 0, then two stop bits of 104 clocks each;
  - single donetx pulse.
- Drive an 8N1 frame 8'h3C on rx at 9600 baud -> donerx pulse; doutrx=8'h3C; perr=0; ferr=0.
- Repeat with the stop bit driven 0 -> ferr=1. Then hold rx low 3000 clocks -> no further donerx until rx returns high and a valid frame arrives.
- rx low for 2 sample ticks (12 clocks), then high -> no donerx; doutrx and flags unchanged.
- rst=0 for one edge midway through the TX data bits -> next cycle tx=1, busytx=0, and no donetx follows.
- Loopback (UART_LOOPBACK_EN, loopback=1): send 8'h5A -> donetx, then donerx with doutrx=8'h5A; tx pin stays 1 throughout.

Source files
------------

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: DATA_BITS payload, optional odd/even parity, 1-2 TX stop bits, oversampled RX.
// Latency: TX line drops the cycle after newd is accepted; donerx pulses the cycle after the stop-bit sample.
// Backpressure: none; newd is ignored while busytx=1. Optional UART_LOOPBACK_EN adds an internal tx->rx loopback port.
module uart_core_param #(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [DATA_BITS-1:0] dintx,
    input  logic                 newd,
`ifdef UART_LOOPBACK_EN
    input  logic                 loopback,
`endif
    output logic                 tx,
    output logic [DATA_BITS-1:0] doutrx,
    output logic                 donetx,
    output logic                 donerx,
    output logic                 busytx,
    output logic                 perr,
    output logic                 ferr
);

    localparam int   BIT_DIV  = CLK_FREQ / BAUD;
    localparam int   SMP_DIV  = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int   STOP_LEN = STOP_BITS * BIT_DIV;
    localparam int   TCW      = $clog2(STOP_LEN + 1);
    localparam int   SCW      = $clog2(SMP_DIV + 1);
    localparam int   OCW      = $clog2(OVERSAMPLE + 1);
    localparam int   BCW      = $clog2(DATA_BITS + 1);
    localparam logic PAR_ODD  = (PARITY == 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               tx_state_q, tx_state_d;
    logic [TCW-1:0]       tx_cnt_q, tx_cnt_d;
    logic [BCW-1:0]       tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_q, tx_d;

    state_t               rx_state_q, rx_state_d;
    logic                 rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
    logic [SCW-1:0]       smp_cnt_q, smp_cnt_d;
    logic [OCW-1:0]       tick_cnt_q, tick_cnt_d;
    logic [BCW-1:0]       rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_q, rx_par_d;
    logic                 rx_brk_q, rx_brk_d;
    logic [DATA_BITS-1:0] doutrx_q, doutrx_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d, donerx_q, donerx_d;

    logic rx_src, tx_bit_end, tx_stop_end, smp_tick, half_pt, bit_pt;

`ifdef UART_LOOPBACK_EN
    assign rx_src = loopback ? tx_q : rx;
    assign tx     = loopback ? 1'b1 : tx_q;
`else
    assign rx_src = rx;
    assign tx     = tx_q;
`endif

    assign tx_bit_end  = (tx_cnt_q == TCW'(BIT_DIV - 1));
    assign tx_stop_end = (tx_cnt_q == TCW'(STOP_LEN - 1));
    assign donetx      = (tx_state_q == S_STOP) && tx_stop_end;
    assign busytx      = (tx_state_q != S_IDLE);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        case (tx_state_q)
            S_IDLE: begin
                tx_cnt_d = '0;
                if (newd) begin
                    tx_state_d = S_START;
                    tx_shift_d = dintx;
                    tx_par_d   = (^dintx) ^ PAR_ODD;
                    tx_d       = 1'b0;
                end
            end
            S_START: if (tx_bit_end) begin
                tx_state_d = S_DATA;
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_d       = tx_shift_q[0];
            end
            S_DATA: if (tx_bit_end) begin
                tx_cnt_d = '0;
                if (tx_bit_q == BCW'(DATA_BITS - 1)) begin
                    tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    tx_d       = (PARITY != 0) ? tx_par_q : 1'b1;
                end else begin
                    tx_bit_d   = tx_bit_q + 1'b1;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_d       = tx_shift_q[1];
                end
            end
            S_PARITY: if (tx_bit_end) begin
                tx_state_d = S_STOP;
                tx_cnt_d   = '0;
                tx_d       = 1'b1;
            end
            S_STOP: if (tx_stop_end) begin
                tx_state_d = S_IDLE;
                tx_cnt_d   = '0;
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    assign smp_tick = (smp_cnt_q == SCW'(SMP_DIV - 1));
    assign half_pt  = smp_tick && (tick_cnt_q == OCW'(OVERSAMPLE / 2 - 1));
    assign bit_pt   = smp_tick && (tick_cnt_q == OCW'(OVERSAMPLE - 1));

    always_comb begin
        rx_s1_d    = rx_src;
        rx_s2_d    = rx_s1_q;
        rx_state_d = rx_state_q;
        smp_cnt_d  = smp_tick ? '0 : smp_cnt_q + 1'b1;
        tick_cnt_d = smp_tick ? tick_cnt_q + 1'b1 : tick_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_brk_d   = rx_brk_q;
        doutrx_d   = doutrx_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        donerx_d   = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                smp_cnt_d  = '0;
                tick_cnt_d = '0;
                // A line held low after a framing error is a break, not a new start bit.
                if (rx_brk_q) begin
                    if (rx_s2_q) rx_brk_d = 1'b0;
                end else if (!rx_s2_q) begin
                    rx_state_d = S_START;
                end
            end
            S_START: if (half_pt) begin
                tick_cnt_d = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
            end
            S_DATA: if (bit_pt) begin
                tick_cnt_d = '0;
                rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                if (rx_bit_q == BCW'(DATA_BITS - 1))
                    rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                else
                    rx_bit_d = rx_bit_q + 1'b1;
            end
            S_PARITY: if (bit_pt) begin
                tick_cnt_d = '0;
                rx_par_d   = rx_s2_q;
                rx_state_d = S_STOP;
            end
            S_STOP: if (bit_pt) begin
                rx_state_d = S_IDLE;
                donerx_d   = 1'b1;
                doutrx_d   = rx_shift_q;
                ferr_d     = ~rx_s2_q;
                rx_brk_d   = ~rx_s2_q;
                perr_d     = (PARITY != 0) && (rx_par_q != ((^rx_shift_q) ^ PAR_ODD));
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            smp_cnt_q  <= '0;
            tick_cnt_q <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_brk_q   <= 1'b0;
            doutrx_q   <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            donerx_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
            rx_state_q <= rx_state_d;
            rx_s1_q    <= rx_s1_d;
            rx_s2_q    <= rx_s2_d;
            smp_cnt_q  <= smp_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_brk_q   <= rx_brk_d;
            doutrx_q   <= doutrx_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            donerx_q   <= donerx_d;
        end
    end

    assign doutrx = doutrx_q;
    assign perr   = perr_q;
    assign ferr   = ferr_q;
    assign donerx = donerx_q;

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param: an 8N1 instance (a) and a 7-bit even-parity 2-stop instance (b).
// Both use OVERSAMPLE=8 so the RX bit time (13 clk x 8 = 104) equals the 9600-baud line bit time at 1 MHz.
module tb_uart_core_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_a, newd_a, tx_a, donetx_a, donerx_a, busytx_a, perr_a, ferr_a;
    logic [7:0] dintx_a, doutrx_a;
    logic       rx_b, newd_b, tx_b, donetx_b, donerx_b, busytx_b, perr_b, ferr_b;
    logic [6:0] dintx_b, doutrx_b;
`ifdef UART_LOOPBACK_EN
    logic       loopback_a, loopback_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_donerx_a = 0;
    int n_donerx_b = 0;

    always #5 clk = ~clk;

    uart_core_param #(.OVERSAMPLE(8)) u_dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .dintx(dintx_a), .newd(newd_a),
`ifdef UART_LOOPBACK_EN
        .loopback(loopback_a),
`endif
        .tx(tx_a), .doutrx(doutrx_a), .donetx(donetx_a), .donerx(donerx_a),
        .busytx(busytx_a), .perr(perr_a), .ferr(ferr_a)
    );

    uart_core_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .OVERSAMPLE(8)) u_dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .dintx(dintx_b), .newd(newd_b),
`ifdef UART_LOOPBACK_EN
        .loopback(loopback_b),
`endif
        .tx(tx_b), .doutrx(doutrx_b), .donetx(donetx_b), .donerx(donerx_b),
        .busytx(busytx_b), .perr(perr_b), .ferr(ferr_b)
    );

    always @(negedge clk) begin
        if (donerx_a === 1'b1) n_donerx_a++;
        if (donerx_b === 1'b1) n_donerx_b++;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends one frame and checks every bit slot of 104 clocks against slots[] (LSB = first slot).
    task automatic tx_frame(input bit sel, input logic [8:0] data, input logic [15:0] slots,
                            input int nslots, input string tag);
        int good, done_n, done_at, busy_n;
        if (sel) begin dintx_b = data[6:0]; newd_b = 1'b1; end
        else     begin dintx_a = data[7:0]; newd_a = 1'b1; end
        @(posedge clk); #1;
        newd_a = 1'b0; newd_b = 1'b0;
        done_n = 0; done_at = -1; busy_n = 0;
        for (int s = 0; s < nslots; s++) begin
            good = 0;
            for (int c = 0; c < 104; c++) begin
                @(negedge clk);
                if ((sel ? tx_b : tx_a) === slots[s]) good++;
                if ((sel ? busytx_b : busytx_a) === 1'b1) busy_n++;
                if ((sel ? donetx_b : donetx_a) === 1'b1) begin done_n++; done_at = s * 104 + c; end
            end
            chk_eq($sformatf("%s_slot%0d", tag, s), good, 104);
        end
        @(negedge clk);
        chk_eq({tag, "_busy_cycles"}, busy_n, nslots * 104);
        chk_eq({tag, "_donetx_count"}, done_n, 1);
        chk_eq({tag, "_donetx_cycle"}, done_at, nslots * 104 - 1);
        chk_eq({tag, "_idle_tx"}, sel ? tx_b : tx_a, 1);
        chk_eq({tag, "_idle_busy"}, sel ? busytx_b : busytx_a, 0);
    endtask

    task automatic rx_drive(input bit sel, input logic [15:0] slots, input int nslots);
        for (int s = 0; s < nslots; s++) begin
            if (sel) rx_b = slots[s]; else rx_a = slots[s];
            step(104);
        end
    endtask

    initial begin
        int base, cnt, lows;
        bit found;
        rst = 1'b0;
        rx_a = 1'b1; newd_a = 1'b0; dintx_a = '0;
        rx_b = 1'b1; newd_b = 1'b0; dintx_b = '0;
`ifdef UART_LOOPBACK_EN
        loopback_a = 1'b0; loopback_b = 1'b0;
`endif
        step(3);
        @(negedge clk);
        chk_eq("rst_tx", tx_a, 1);
        chk_eq("rst_busytx", busytx_a, 0);
        chk_eq("rst_donetx", donetx_a, 0);
        chk_eq("rst_donerx", donerx_a, 0);
        chk_eq("rst_doutrx", doutrx_a, 0);
        chk_eq("rst_perr", perr_a, 0);
        chk_eq("rst_ferr", ferr_a, 0);
        chk_eq("rst_tx_b", tx_b, 1);
        step(1);
        rst = 1'b1;
        step(2);

        // 8N1 0xA5: start 0, data LSB first, stop 1.
        tx_frame(1'b0, 9'h0A5, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, "tx_a5");
        step(5);
        // 7 data bits 0x41 (two ones -> even parity 0), two stop bits.
        tx_frame(1'b1, 9'h041, {5'b0, 2'b11, 1'b0, 7'h41, 1'b0}, 11, "tx_41e2");
        step(5);

        // newd held high: exactly one idle-high cycle between frames.
        dintx_a = 8'h00; newd_a = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 1200 && !found; i++) begin
            @(negedge clk);
            if (donetx_a === 1'b1) found = 1'b1;
        end
        chk_eq("held_first_donetx", found, 1);
        @(negedge clk);
        chk_eq("held_gap_tx", tx_a, 1);
        chk_eq("held_gap_busy", busytx_a, 0);
        @(negedge clk);
        chk_eq("held_restart_tx", tx_a, 0);
        chk_eq("held_restart_busy", busytx_a, 1);
        newd_a = 1'b0;
        cnt = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (donetx_a === 1'b1) cnt++;
        end
        chk_eq("held_second_donetx", cnt, 1);
        chk_eq("held_end_busy", busytx_a, 0);
        step(1);

        // Reset during data bit 3 aborts the frame silently.
        dintx_a = 8'hA5; newd_a = 1'b1;
        step(1);
        newd_a = 1'b0;
        step(104 + 3 * 104);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        @(negedge clk);
        chk_eq("abort_tx", tx_a, 1);
        chk_eq("abort_busy", busytx_a, 0);
        cnt = 0; lows = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (donetx_a === 1'b1) cnt++;
            if (tx_a !== 1'b1) lows++;
        end
        chk_eq("abort_no_donetx", cnt, 0);
        chk_eq("abort_tx_low_cycles", lows, 0);
        step(1);

        // RX valid 8N1 frame 0x3C.
        base = n_donerx_a;
        rx_drive(1'b0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10);
        step(20);
        chk_eq("rx3c_donerx", n_donerx_a - base, 1);
        chk_eq("rx3c_dout", doutrx_a, 8'h3C);
        chk_eq("rx3c_perr", perr_a, 0);
        chk_eq("rx3c_ferr", ferr_a, 0);

        // Stop bit 0 followed by a 3000-clock break.
        base = n_donerx_a;
        rx_drive(1'b0, {6'b0, 1'b0, 8'h81, 1'b0}, 10);
        step(3000);
        chk_eq("ferr_donerx", n_donerx_a - base, 1);
        chk_eq("ferr_dout", doutrx_a, 8'h81);
        chk_eq("ferr_flag", ferr_a, 1);
        rx_a = 1'b1;
        step(200);
        rx_drive(1'b0, {6'b0, 1'b1, 8'hC3, 1'b0}, 10);
        step(20);
        chk_eq("post_break_donerx", n_donerx_a - base, 2);
        chk_eq("post_break_dout", doutrx_a, 8'hC3);
        chk_eq("post_break_ferr", ferr_a, 0);

        // Two-tick low glitch is rejected.
        base = n_donerx_a;
        rx_a = 1'b0;
        step(26);
        rx_a = 1'b1;
        step(300);
        chk_eq("glitch_donerx", n_donerx_a - base, 0);
        chk_eq("glitch_dout", doutrx_a, 8'hC3);
        chk_eq("glitch_ferr", ferr_a, 0);
        chk_eq("glitch_perr", perr_a, 0);

        // Even parity RX: 0x41 with parity 0 is good; 0x13 (three ones) with parity 0 is bad.
        base = n_donerx_b;
        rx_drive(1'b1, {6'b0, 1'b1, 1'b0, 7'h41, 1'b0}, 10);
        step(20);
        chk_eq("rxpar_ok_donerx", n_donerx_b - base, 1);
        chk_eq("rxpar_ok_dout", doutrx_b, 7'h41);
        chk_eq("rxpar_ok_perr", perr_b, 0);
        rx_drive(1'b1, {6'b0, 1'b1, 1'b0, 7'h13, 1'b0}, 10);
        step(20);
        chk_eq("rxpar_bad_donerx", n_donerx_b - base, 2);
        chk_eq("rxpar_bad_dout", doutrx_b, 7'h13);
        chk_eq("rxpar_bad_perr", perr_b, 1);
        chk_eq("rxpar_bad_ferr", ferr_b, 0);

`ifdef UART_LOOPBACK_EN
        base = n_donerx_b;
        loopback_b = 1'b1;
        rx_b = 1'b0;
        step(2);
        dintx_b = 7'h5A; newd_b = 1'b1;
        step(1);
        newd_b = 1'b0;
        cnt = 0; lows = 0;
        for (int i = 0; i < 1300; i++) begin
            @(negedge clk);
            if (donetx_b === 1'b1) cnt++;
            if (tx_b !== 1'b1) lows++;
        end
        chk_eq("lb_donetx", cnt, 1);
        chk_eq("lb_tx_pin_low_cycles", lows, 0);
        chk_eq("lb_donerx", n_donerx_b - base, 1);
        chk_eq("lb_dout", doutrx_b, 7'h5A);
        chk_eq("lb_perr", perr_b, 0);
        rx_b = 1'b1;
        step(5);
        loopback_b = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
